// File: rtl/da_dds_wave_gen_if.sv
// Bundles the DDS control, ROM and DAC signals of da_dds_wave_gen.
// The master modport is the side that drives control and ROM data; the slave modport is the generator.
interface da_dds_wave_gen_if #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned ACC_W  = 24
);
    localparam int unsigned AMP_W = 9;

    // Run and configuration control
    logic              en;
    logic              cfg_load;
    logic              cfg_imm;
    logic [ACC_W-1:0]  ftw_in;
    logic [ADDR_W-1:0] phase_in;
    logic [AMP_W-1:0]  amp_in;
    logic              cfg_pending;

    // Waveform ROM port
    logic [ADDR_W-1:0] rom_addr;
    logic [DATA_W-1:0] rom_data;

    // DAC pins and cycle marker
    logic              da_clk;
    logic [DATA_W-1:0] da_data;
    logic              da_valid;
    logic              sync;

    modport master (
        output en, cfg_load, cfg_imm, ftw_in, phase_in, amp_in, rom_data,
        input  cfg_pending, rom_addr, da_clk, da_data, da_valid, sync
    );

    modport slave (
        input  en, cfg_load, cfg_imm, ftw_in, phase_in, amp_in, rom_data,
        output cfg_pending, rom_addr, da_clk, da_data, da_valid, sync
    );
endinterface

// File: rtl/da_dds_wave_gen.sv
// DDS waveform sender for an offset-binary DAC: phase accumulator, phase offset,
// amplitude scaling about mid-scale and wrap-synchronised configuration commit.
module da_dds_wave_gen #(
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned ADDR_W  = 8,
    parameter int unsigned ACC_W   = 24,
    parameter int unsigned ROM_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    da_dds_wave_gen_if.slave  bus
);
    localparam int unsigned AMP_W  = 9;
    localparam int unsigned PROD_W = DATA_W + AMP_W + 1;
    localparam int unsigned VLD_N  = ROM_LAT + 2;
    localparam logic [AMP_W-1:0]  AMP_UNITY = AMP_W'(256);
    localparam logic [DATA_W-1:0] MID       = {1'b1, {(DATA_W-1){1'b0}}};

    typedef struct packed {
        logic [ACC_W-1:0]  ftw;
        logic [ADDR_W-1:0] phase;
        logic [AMP_W-1:0]  amp;
    } cfg_t;

    typedef enum logic [0:0] {
        CFG_IDLE = 1'b0,
        CFG_PEND = 1'b1
    } cfg_state_t;

    cfg_state_t        state_q, state_d;
    cfg_t              act_q, act_d;
    cfg_t              shadow_q, shadow_d;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
    logic [VLD_N-1:0]  vld_q, vld_d;
    logic [DATA_W-1:0] da_data_q, da_data_d;
    logic              sync_q, sync_d;

    logic [ACC_W:0]     acc_sum_c;
    logic               wrap_c;
    logic [AMP_W-1:0]   amp_clamp_c;
    cfg_t               cfg_in_c;
    logic [DATA_W-1:0]  samp_c;
    logic [PROD_W-1:0]  samp_x_c;
    logic [PROD_W-1:0]  amp_x_c;
    logic signed [PROD_W-1:0] prod_c;
    logic [DATA_W-1:0]  scaled_c;
    logic               unused_prod;

    // Phase accumulator; the carry out of the add marks the wrap
    assign acc_sum_c = {1'b0, acc_q} + {1'b0, act_q.ftw};
    assign wrap_c    = bus.en & acc_sum_c[ACC_W];
    assign acc_d     = bus.en ? acc_sum_c[ACC_W-1:0] : acc_q;

    assign amp_clamp_c = (bus.amp_in > AMP_UNITY) ? AMP_UNITY : bus.amp_in;
    assign cfg_in_c    = '{ftw: bus.ftw_in, phase: bus.phase_in, amp: amp_clamp_c};

    // Config commit: immediate when idle-running is not disturbed, otherwise parked until a wrap
    always_comb begin
        state_d  = state_q;
        act_d    = act_q;
        shadow_d = shadow_q;
        if (bus.cfg_load) begin
            if (bus.cfg_imm || !bus.en) begin
                act_d   = cfg_in_c;
                state_d = CFG_IDLE;
            end else begin
                shadow_d = cfg_in_c;
                state_d  = CFG_PEND;
            end
        end else if (state_q == CFG_PEND && (wrap_c || !bus.en)) begin
            act_d   = shadow_q;
            state_d = CFG_IDLE;
        end
    end

    // Offset-binary sample to signed, scale by amp/256 with floor, back to offset-binary
    assign samp_c   = bus.rom_data ^ MID;
    assign samp_x_c = {{(PROD_W-DATA_W){samp_c[DATA_W-1]}}, samp_c};
    assign amp_x_c  = {{(PROD_W-AMP_W){1'b0}}, act_q.amp};
    assign prod_c   = $signed(samp_x_c) * $signed(amp_x_c);
    assign scaled_c = prod_c[DATA_W+7:8] ^ MID;
    assign unused_prod = ^{prod_c[PROD_W-1:DATA_W+8], prod_c[7:0]};

    always_comb begin
        rom_addr_d = acc_q[ACC_W-1 -: ADDR_W] + act_q.phase;
        vld_d      = {vld_q[VLD_N-2:0], bus.en};
        da_data_d  = vld_q[VLD_N-2] ? scaled_c : MID;
        sync_d     = wrap_c;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= CFG_IDLE;
            act_q      <= '{ftw: '0, phase: '0, amp: AMP_UNITY};
            shadow_q   <= '0;
            acc_q      <= '0;
            rom_addr_q <= '0;
            vld_q      <= '0;
            da_data_q  <= MID;
            sync_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            act_q      <= act_d;
            shadow_q   <= shadow_d;
            acc_q      <= acc_d;
            rom_addr_q <= rom_addr_d;
            vld_q      <= vld_d;
            da_data_q  <= da_data_d;
            sync_q     <= sync_d;
        end
    end

    // DAC latches on the falling clk edge, so its clock is the inverted system clock
    assign bus.da_clk      = ~clk;
    assign bus.rom_addr    = rom_addr_q;
    assign bus.da_data     = da_data_q;
    assign bus.da_valid    = vld_q[VLD_N-1];
    assign bus.sync        = sync_q;
    assign bus.cfg_pending = (state_q == CFG_PEND);
endmodule

// File: tb/tb_da_dds_wave_gen.sv
// Bench for da_dds_wave_gen: a cycle-level reference model predicts every output,
// a monitor on the falling edge compares the DUT against the queued predictions.
module tb_da_dds_wave_gen;
    localparam int unsigned DATA_W  = 8;
    localparam int unsigned ADDR_W  = 8;
    localparam int unsigned ACC_W   = 24;
    localparam int unsigned ROM_LAT = 1;
    localparam longint ACC_MOD = 64'd1 << ACC_W;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    da_dds_wave_gen_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ACC_W(ACC_W)) bus ();

    da_dds_wave_gen #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ACC_W(ACC_W), .ROM_LAT(ROM_LAT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Address-pattern ROM with one cycle of read latency
    always @(posedge clk) bus.rom_data <= bus.rom_addr;

    typedef struct {
        int addr;
        int data;
        int valid;
        int sync;
        int pend;
    } exp_t;

    exp_t exp_q[$];
    int n_chk = 0;
    int n_fail = 0;

    // Reference model state
    longint m_acc = 0, m_ftw = 0, s_ftw = 0;
    int m_ph = 0, m_amp = 256, s_ph = 0, s_amp = 256, m_pend = 0;
    int a_h1 = 0, a_h2 = 0, e_h1 = 0, e_h2 = 0;

    task automatic chk(input string name, input int act, input int expv);
        n_chk++;
        if (act != expv) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, expv, $time);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_chk++;
        n_fail++;
        $display("FAIL %s: wait bound expired at %0t", name, $time);
    endtask

    function automatic int scale(input int d, input int a);
        int s, p, y;
        s = d - 128;
        p = s * a;
        if (p >= 0) y = p / 256;
        else        y = -((-p + 255) / 256);
        return y + 128;
    endfunction

    function automatic void model_reset();
        m_acc = 0; m_ftw = 0; s_ftw = 0;
        m_ph = 0; m_amp = 256; s_ph = 0; s_amp = 256; m_pend = 0;
        a_h1 = 0; a_h2 = 0; e_h1 = 0; e_h2 = 0;
    endfunction

    // Model: one step per rising edge, from the inputs the DUT samples on that edge
    always @(posedge clk or negedge rst_n) begin
        exp_t e;
        int addr_new, amp_new, en_v;
        longint sum;
        bit wrap;
        if (!rst_n) begin
            model_reset();
            exp_q.delete();
            if (clk) begin
                e = '{addr: 0, data: 128, valid: 0, sync: 0, pend: 0};
                exp_q.push_back(e);
            end
        end else begin
            en_v     = int'(bus.en);
            addr_new = int'(((m_acc >> (ACC_W - ADDR_W)) + longint'(m_ph)) % 256);
            e.valid  = e_h2;
            e.data   = e_h2 ? scale(a_h2, m_amp) : 128;
            e.addr   = addr_new;
            sum      = m_acc + m_ftw;
            wrap     = (en_v != 0) && (sum >= ACC_MOD);
            if (en_v != 0) m_acc = sum % ACC_MOD;
            amp_new  = (int'(bus.amp_in) > 256) ? 256 : int'(bus.amp_in);
            if (bus.cfg_load) begin
                if (bus.cfg_imm || en_v == 0) begin
                    m_ftw = longint'(bus.ftw_in); m_ph = int'(bus.phase_in); m_amp = amp_new; m_pend = 0;
                end else begin
                    s_ftw = longint'(bus.ftw_in); s_ph = int'(bus.phase_in); s_amp = amp_new; m_pend = 1;
                end
            end else if (m_pend != 0 && (wrap || en_v == 0)) begin
                m_ftw = s_ftw; m_ph = s_ph; m_amp = s_amp; m_pend = 0;
            end
            e.sync = wrap ? 1 : 0;
            e.pend = m_pend;
            a_h2 = a_h1; a_h1 = addr_new;
            e_h2 = e_h1; e_h1 = en_v;
            exp_q.push_back(e);
        end
    end

    // Monitor: compare the DUT with the oldest prediction, half a cycle after the edge
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("rom_addr",    int'(bus.rom_addr),    e.addr);
            chk("da_valid",    int'(bus.da_valid),    e.valid);
            chk("da_data",     int'(bus.da_data),     e.data);
            chk("sync",        int'(bus.sync),        e.sync);
            chk("cfg_pending", int'(bus.cfg_pending), e.pend);
        end
    end

    task automatic run(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic load(input int ftw, input int ph, input int amp, input bit imm);
        bus.ftw_in   = ACC_W'(ftw);
        bus.phase_in = ADDR_W'(ph);
        bus.amp_in   = 9'(amp);
        bus.cfg_imm  = imm;
        bus.cfg_load = 1'b1;
        @(negedge clk);
        bus.cfg_load = 1'b0;
        bus.cfg_imm  = 1'b0;
    endtask

    task automatic wait_acc(input longint target, input int max_cyc);
        int c = 0;
        while (m_acc != target && c < max_cyc) begin
            @(negedge clk);
            c++;
        end
        if (m_acc != target) timeout_fail("wait_acc");
    endtask

    task automatic wait_wrap_next(input int max_cyc);
        int c = 0;
        while (!(bus.en && (m_acc + m_ftw >= ACC_MOD)) && c < max_cyc) begin
            @(negedge clk);
            c++;
        end
        if (!(bus.en && (m_acc + m_ftw >= ACC_MOD))) timeout_fail("wait_wrap");
    endtask

    initial begin
        bus.en = 1'b0; bus.cfg_load = 1'b0; bus.cfg_imm = 1'b0;
        bus.ftw_in = '0; bus.phase_in = '0; bus.amp_in = 9'd256;
        run(3);
        rst_n = 1'b1;
        run(2);

        // Unity amplitude ramp, one address per cycle, sync every 256 cycles
        load(32'h010000, 0, 256, 1'b0);
        bus.en = 1'b1;
        run(300);

        // Half, zero and over-unity amplitude
        load(32'h010000, 0, 128, 1'b1);
        run(260);
        load(32'h010000, 0, 0, 1'b1);
        run(20);
        load(32'h010000, 0, 300, 1'b1);
        run(20);

        // Asynchronous reset mid-run returns outputs at once
        #2 rst_n = 1'b0;
        #1;
        chk("rst_rom_addr",    int'(bus.rom_addr),    0);
        chk("rst_da_data",     int'(bus.da_data),     128);
        chk("rst_da_valid",    int'(bus.da_valid),    0);
        chk("rst_sync",        int'(bus.sync),        0);
        chk("rst_cfg_pending", int'(bus.cfg_pending), 0);
        bus.en = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        run(2);

        // Phase offset 0x40 from acc=0
        load(32'h010000, 8'h40, 256, 1'b0);
        bus.en = 1'b1;
        run(270);

        // Deferred commit issued at mid-period
        wait_acc(64'h800000, 400);
        load(32'h020000, 0, 256, 1'b0);
        run(200);

        // Load coincident with a wrap waits one more period
        wait_wrap_next(300);
        load(32'h010000, 8'h10, 200, 1'b0);
        run(300);

        // Shadow overwritten while pending; only the last one commits
        load(32'h030000, 0, 100, 1'b0);
        run(5);
        load(32'h008000, 8'h20, 256, 1'b0);
        run(600);

        // en dropped while pending commits on the next cycle; outputs freeze and go mid-scale
        load(32'h040000, 0, 180, 1'b0);
        bus.en = 1'b0;
        run(10);
        bus.en = 1'b1;
        run(20);

        // Randomised run
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 15) == 0) bus.en = ~bus.en;
            if ($urandom_range(0, 19) == 0)
                load(($urandom_range(0, 7) == 0) ? 0 : int'($urandom & 32'h0FFFFF),
                     int'($urandom_range(0, 255)), int'($urandom_range(0, 511)),
                     1'($urandom_range(0, 1)));
            else
                @(negedge clk);
        end

        bus.en = 1'b0;
        run(10);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
